// File: rtl/riscv_wb_regfile_pkg.sv
// Shared widths and encodings for the writeback stage and integer register file.
// Load funct3 codes follow the RV32I base ISA.
package riscv_wb_regfile_pkg;
  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic RD_SRC_ALU = 1'b0;
  localparam logic RD_SRC_MEM = 1'b1;
endpackage

// File: rtl/riscv_load_extend.sv
// Lane-aligns a raw memory word by byte offset and sign/zero-extends per load funct3.
// Purely combinational so a MEM-stage forwarding path can reuse it.
module riscv_load_extend
  import riscv_wb_regfile_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [2:0]   funct3_i,
  input  logic [1:0]   off_i,
  input  logic [W-1:0] word_i,
  output logic [W-1:0] data_o
);
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word_i[7:0];
    case (off_i)
      2'd0: byte_lane = word_i[7:0];
      2'd1: byte_lane = word_i[15:8];
      2'd2: byte_lane = word_i[23:16];
      2'd3: byte_lane = word_i[31:24];
      default: byte_lane = word_i[7:0];
    endcase
  end

  // off[0] is deliberately ignored: misalignment is trapped upstream, not here.
  assign half_lane = off_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    data_o = word_i;
    case (funct3_i)
      F3_LB:   data_o = {{(W-8){byte_lane[7]}}, byte_lane};
      F3_LBU:  data_o = {{(W-8){1'b0}}, byte_lane};
      F3_LH:   data_o = {{(W-16){half_lane[15]}}, half_lane};
      F3_LHU:  data_o = {{(W-16){1'b0}}, half_lane};
      F3_LW:   data_o = word_i;
      default: data_o = word_i;
    endcase
  end
endmodule

// File: rtl/riscv_wb_regfile.sv
// Writeback stage plus architectural x0..x31 register file with write-first
// WB-to-ID bypass on both read ports and a wrapping commit counter.
module riscv_wb_regfile
  import riscv_wb_regfile_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wb_ctrl_reg_write,
  input  logic              i_wb_ctrl_rd_src,
  input  logic [2:0]        i_wb_load_funct3,
  input  logic [4:0]        i_wb_rd_addr,
  input  logic [XLEN_P-1:0] i_wb_rd_result,
  input  logic [XLEN_P-1:0] i_wb_read_data,
  input  logic [4:0]        i_id_rs1_addr,
  input  logic [4:0]        i_id_rs2_addr,
  output logic [XLEN_P-1:0] o_id_rs1_data,
  output logic [XLEN_P-1:0] o_id_rs2_data,
  output logic [XLEN_P-1:0] o_wb_rd_data,
  output logic [CNT_W-1:0]  o_wb_commit_cnt
);
  // x0 is hardwired, so storage starts at index 1.
  logic [XLEN_P-1:0] regs_q [1:31];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN_P-1:0] load_data;
  logic              commit;

  riscv_load_extend #(.W(XLEN_P)) u_load_extend (
    .funct3_i (i_wb_load_funct3),
    .off_i    (i_wb_rd_result[1:0]),
    .word_i   (i_wb_read_data),
    .data_o   (load_data)
  );

  assign o_wb_rd_data = (i_wb_ctrl_rd_src == RD_SRC_MEM) ? load_data : i_wb_rd_result;
  assign commit       = i_wb_ctrl_reg_write && (i_wb_rd_addr != 5'd0);
  assign cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
      cnt_q <= '0;
    end else if (commit) begin
      regs_q[i_wb_rd_addr] <= o_wb_rd_data;
      cnt_q                <= cnt_d;
    end
  end

  function automatic logic [XLEN_P-1:0] read_port(input logic [4:0] rs);
    if (rs == 5'd0)                        return '0;
    else if (commit && rs == i_wb_rd_addr) return o_wb_rd_data;
    else                                   return regs_q[rs];
  endfunction

  assign o_id_rs1_data   = read_port(i_id_rs1_addr);
  assign o_id_rs2_data   = read_port(i_id_rs2_addr);
  assign o_wb_commit_cnt = cnt_q;
endmodule

// File: tb/tb_riscv_wb_regfile.sv
// Directed bench with a per-cycle reference model of the register file and
// literal checks for the documented scenarios; a CNT_W=4 copy covers counter wrap.
module tb_riscv_wb_regfile;
  logic        clk = 1'b0;
  logic        rst, we, rd_src;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] res, rdata;
  logic [31:0] rs1_d, rs2_d, wb_d, cnt;
  logic [31:0] rs1_d4, rs2_d4, wb_d4;
  logic [3:0]  cnt4;

  int ntests = 0;
  int nfail  = 0;
  bit model_on = 1'b0;

  logic [31:0] m_regs [0:31];
  int unsigned m_cnt;

  always #5 clk = ~clk;

  riscv_wb_regfile u_dut (
    .i_clk(clk), .i_rst(rst), .i_wb_ctrl_reg_write(we), .i_wb_ctrl_rd_src(rd_src),
    .i_wb_load_funct3(f3), .i_wb_rd_addr(rd), .i_wb_rd_result(res), .i_wb_read_data(rdata),
    .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2), .o_id_rs1_data(rs1_d), .o_id_rs2_data(rs2_d),
    .o_wb_rd_data(wb_d), .o_wb_commit_cnt(cnt)
  );

  riscv_wb_regfile #(.CNT_W(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_wb_ctrl_reg_write(we), .i_wb_ctrl_rd_src(rd_src),
    .i_wb_load_funct3(f3), .i_wb_rd_addr(rd), .i_wb_rd_result(res), .i_wb_read_data(rdata),
    .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2), .o_id_rs1_data(rs1_d4), .o_id_rs2_data(rs2_d4),
    .o_wb_rd_data(wb_d4), .o_wb_commit_cnt(cnt4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference load semantics: shift the wanted lane down, mask, extend.
  function automatic logic [31:0] m_load(input logic [2:0] fn, input logic [31:0] addr,
                                         input logic [31:0] w);
    int unsigned sh;
    logic [31:0] v;
    case (fn)
      3'b000, 3'b100: begin
        sh = 8 * addr[1:0];
        v  = (w >> sh) & 32'hFF;
        if (fn == 3'b000 && v[7]) v = v | 32'hFFFFFF00;
        return v;
      end
      3'b001, 3'b101: begin
        sh = addr[1] ? 16 : 0;
        v  = (w >> sh) & 32'hFFFF;
        if (fn == 3'b001 && v[15]) v = v | 32'hFFFF0000;
        return v;
      end
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_wb();
    return rd_src ? m_load(f3, res, rdata) : res;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (we && rd == a) return m_wb();
    return m_regs[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cnt = 0;
    end else if (we && rd != 0) begin
      m_regs[rd] = m_wb();
      m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("model_wb",   wb_d,  m_wb());
      chk("model_rs1",  rs1_d, m_read(rs1));
      chk("model_rs2",  rs2_d, m_read(rs2));
      chk("model_cnt",  cnt,   m_cnt);
      chk("model_cnt4", {28'h0, cnt4}, m_cnt % 16);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    we = 1'b1; rd_src = 1'b0; rd = a; res = v;
  endtask

  typedef struct { logic [2:0] fn; logic [31:0] addr; logic [31:0] exp; string nm; } ld_vec_t;
  ld_vec_t lv [5];

  initial begin
    rst = 1'b1; we = 1'b0; rd_src = 1'b0; f3 = 3'b010; rd = '0; res = '0; rdata = '0;
    rs1 = '0; rs2 = '0;
    step(); step();
    rst = 1'b0; model_on = 1'b1;

    // Preload every register, then reset with a concurrent write to x5.
    for (int i = 1; i < 32; i++) begin
      wr(i[4:0], 32'h01010101 * i);
      step();
    end
    rst = 1'b1; wr(5'd5, 32'h1234);
    step();
    rst = 1'b0; we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = i[4:0]; #1;
      chk("reset_read", rs1_d, 32'h0);
    end
    chk("reset_cnt", cnt, 32'h0);

    // Bypass then storage.
    wr(5'd3, 32'hDEADBEEF); rs1 = 5'd3; #1;
    chk("bypass_x3", rs1_d, 32'hDEADBEEF);
    step();
    we = 1'b0; #1;
    chk("stored_x3", rs1_d, 32'hDEADBEEF);
    chk("cnt_after_x3", cnt, 32'd1);

    // x0 writes are discarded.
    wr(5'd0, 32'hFFFFFFFF); rs1 = 5'd0; rs2 = 5'd0; #1;
    chk("x0_rs1_same", rs1_d, 32'h0);
    chk("x0_rs2_same", rs2_d, 32'h0);
    step();
    we = 1'b0; #1;
    chk("x0_rs1_after", rs1_d, 32'h0);
    chk("x0_cnt", cnt, 32'd1);

    // Load extraction into x7.
    lv[0] = '{3'b000, 32'h1003, 32'hFFFFFF80, "LB_off3"};
    lv[1] = '{3'b100, 32'h1003, 32'h00000080, "LBU_off3"};
    lv[2] = '{3'b001, 32'h1002, 32'hFFFF80F1, "LH_off2"};
    lv[3] = '{3'b101, 32'h1000, 32'h00007F02, "LHU_off0"};
    lv[4] = '{3'b010, 32'h1001, 32'h80F17F02, "LW"};
    rdata = 32'h80F17F02;
    foreach (lv[k]) begin
      we = 1'b1; rd_src = 1'b1; rd = 5'd7; f3 = lv[k].fn; res = lv[k].addr; rs1 = 5'd0; #1;
      chk({lv[k].nm, "_wb"}, wb_d, lv[k].exp);
      step();
      we = 1'b0; rs1 = 5'd7; #1;
      chk({lv[k].nm, "_x7"}, rs1_d, lv[k].exp);
    end
    rd_src = 1'b0; f3 = 3'b010;

    // Back-to-back writes to x9 with rs2 held.
    rs2 = 5'd9;
    for (int v = 1; v <= 3; v++) begin
      wr(5'd9, v); #1;
      chk("x9_b2b", rs2_d, v);
      step();
    end
    we = 1'b0; #1;
    chk("x9_final", rs2_d, 32'd3);
    chk("x9_cnt", cnt, 32'd9);

    // Counter wrap on the CNT_W=4 copy.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      wr(5'd10 + i[4:0] % 5'd8, i); step();
    end
    we = 1'b0; #1;
    chk("cnt4_15", {28'h0, cnt4}, 32'd15);
    wr(5'd20, 32'hA5A5A5A5); step();
    we = 1'b0; #1;
    chk("cnt4_wrap", {28'h0, cnt4}, 32'd0);
    chk("cnt32_16", cnt, 32'd16);

    step();
    model_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
